// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM encoding
// and helpers that size the slice count and slice index.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ns(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int calc_iw(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead block: per-bit generate/propagate
// with every carry expanded directly from the slice carry-in.
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] sum,
  output logic             co
);

  logic [SLICE-1:0] g, p;
  logic [SLICE:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, flattened rather than rippled
  for (genvar i = 0; i < SLICE; i++) begin : g_cla
    logic cy, pp;
    always_comb begin
      cy = g[i];
      pp = p[i];
      for (int k = i - 1; k >= 0; k--) begin
        cy = cy | (pp & g[k]);
        pp = pp & p[k];
      end
      cy = cy | (pp & ci);
    end
    assign c[i+1] = cy;
  end

  assign sum = p ^ c[SLICE-1:0];
  assign co  = c[SLICE];

endmodule

// File: rtl/cla_seq_add.sv
// Multi-cycle adder/subtractor: one SLICE-bit lookahead slice reused NS times
// with a registered carry. Subtraction is built only when CLA_SEQ_SUB_EN is defined.
module cla_seq_add
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NS = calc_ns(WIDTH, SLICE);
  localparam int IW = calc_iw(NS);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, b_in;
  logic             cy_r, c_in;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             accept, last;

`ifdef CLA_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = b;
  assign c_in       = ci;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == IW'(NS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign sl_a = a_r[idx*SLICE +: SLICE];
  assign sl_b = b_r[idx*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .ci  (cy_r),
    .sum (sl_s),
    .co  (sl_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      cy_r <= 1'b0;
      idx  <= '0;
      s    <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b_in;
      cy_r <= c_in;
      idx  <= '0;
      s    <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN) begin
      s[idx*SLICE +: SLICE] <= sl_s;
      cy_r <= sl_co;
      // Parking idx at 0 keeps the slice select in range outside RUN.
      idx  <= last ? '0 : idx + 1'b1;
      if (last) begin
        co  <= sl_co;
        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_s[SLICE-1] != a_r[WIDTH-1]);
      end
    end
  end

endmodule
